neuron_seq_ctrl: RTL and testbench

- Sequencing and output stage directly downstream of the 16-input `Neuron` datapath.
- Drives the neuron's `Neuron_Reset` to flush its multiplier/adder-tree/accumulator pipeline, and windows NUM_CHUNKS consecutive 16-pixel chunks via `Feed_En`/`Chunk_Idx`.
- Captures the accumulator output exactly when the last chunk has fully drained through the pipeline.
- Presents the result raw and as a ReLU-activated, shifted, saturated activation for the next layer.

---
 rtl/neuron_seq_ctrl.sv | 109 ++++++++++
 tb/tb_neuron_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - chunk sequencer, pipeline-drain capture and quantized activation for the 16-input neuron
module neuron_seq_ctrl #(
  parameter int NUM_CHUNKS = 49,
  parameter int CIDX_W     = 6,
  parameter int PIPE_LAT   = 6,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = 8
) (
  input  logic                     Clk,
  input  logic                     GlobalReset,
  input  logic                     Start,
  input  logic                     Abort,
  input  logic signed [25:0]       Acc_In,
  output logic                     Neuron_Reset,
  output logic                     Feed_En,
  output logic [CIDX_W-1:0]        Chunk_Idx,
  output logic                     Busy,
  output logic                     Done,
  output logic signed [25:0]       Result,
  output logic [OUT_W-1:0]         Result_Q
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CIDX_W-1:0]  LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [DW-1:0]      DRAIN_LOAD = DW'(PIPE_LAT - 1);
  localparam logic signed [25:0] Q_LIMIT    = 26'(2 ** OUT_W);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t              state, state_next;
  logic [CIDX_W-1:0]   chunk_next;
  logic [DW-1:0]       drain_cnt, drain_next;
  logic                capture;
  logic signed [25:0]  shifted;
  logic [OUT_W-1:0]    q_next;

  always_comb begin
    state_next = state;
    chunk_next = Chunk_Idx;
    drain_next = drain_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        chunk_next = '0;
        if (Start) state_next = FEED;
      end
      FEED: begin
        chunk_next = Chunk_Idx + 1'b1;
        if (Chunk_Idx == LAST_CHUNK) begin
          state_next = DRAIN;
          chunk_next = '0;
          drain_next = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // Acc_In holds the complete sum only in the final drain cycle
        if (drain_cnt == '0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else begin
          drain_next = drain_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (Abort) begin
      state_next = IDLE;
      chunk_next = '0;
      capture    = 1'b0;
    end
  end

  always_comb begin
    shifted = Acc_In >>> FRAC_SHIFT;
    q_next  = shifted[OUT_W-1:0];
    if (Acc_In[25])
      q_next = '0;
    else if (shifted >= Q_LIMIT)
      q_next = '1;
  end

  // Control outputs are registered from the next state so they are glitch-free for the neuron
  always_ff @(posedge Clk) begin
    if (GlobalReset) begin
      state        <= IDLE;
      Neuron_Reset <= 1'b1;
      Feed_En      <= 1'b0;
      Chunk_Idx    <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      drain_cnt    <= '0;
      Result       <= '0;
      Result_Q     <= '0;
    end else begin
      state        <= state_next;
      Neuron_Reset <= (state_next == IDLE);
      Feed_En      <= (state_next == FEED);
      Busy         <= (state_next != IDLE);
      Chunk_Idx    <= chunk_next;
      drain_cnt    <= drain_next;
      Done         <= capture;
      if (capture) begin
        Result   <= Acc_In;
        Result_Q <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// tb/tb_neuron_seq_ctrl.sv - scoreboard bench for neuron_seq_ctrl with a behavioural neuron pipeline
module tb_neuron_seq_ctrl;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int PL = 6;

  logic              Clk = 1'b0;
  logic              GlobalReset, Start, Abort;
  logic signed [25:0] Acc_In;
  logic              Neuron_Reset, Feed_En, Busy, Done;
  logic [CW-1:0]     Chunk_Idx;
  logic signed [25:0] Result;
  logic [7:0]        Result_Q;

  always #5 Clk = ~Clk;

  neuron_seq_ctrl #(.NUM_CHUNKS(NC), .CIDX_W(CW), .PIPE_LAT(PL), .FRAC_SHIFT(8), .OUT_W(8)) dut (
    .Clk(Clk), .GlobalReset(GlobalReset), .Start(Start), .Abort(Abort), .Acc_In(Acc_In),
    .Neuron_Reset(Neuron_Reset), .Feed_En(Feed_En), .Chunk_Idx(Chunk_Idx), .Busy(Busy),
    .Done(Done), .Result(Result), .Result_Q(Result_Q)
  );

  // Neuron stand-in: per-chunk sums pass PL-1 stages then accumulate; flushed by Neuron_Reset
  logic signed [25:0] vals [NC];
  logic signed [25:0] pipe [PL-1];
  logic signed [25:0] acc;
  logic signed [25:0] feed;
  int                 garb_mode;

  assign Acc_In = acc;
  always_comb feed = Feed_En ? vals[Chunk_Idx] : ((garb_mode != 0) ? vals[NC-1] : 26'sd0);

  always @(posedge Clk) begin
    if (Neuron_Reset) begin
      for (int k = 0; k < PL-1; k++) pipe[k] <= '0;
      acc <= '0;
    end else begin
      pipe[0] <= feed;
      for (int k = 1; k < PL-1; k++) pipe[k] <= pipe[k-1];
      acc <= acc + pipe[PL-2];
    end
  end

  typedef struct {
    logic signed [25:0] res;
    logic [7:0]         q;
    int                 dcyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0, feed_cnt = 0;
  logic signed [25:0] last_res;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] act(input logic signed [25:0] r);
    if (r < 0) return 8'h00;
    if ((r >>> 8) > 26'sd255) return 8'hFF;
    return r[15:8];
  endfunction

  always @(negedge Clk) begin
    if (Done === 1'b1) begin
      check("done_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result", Result, e.res);
        check("result_q", Result_Q, e.q);
        check("done_cycle", cyc, e.dcyc);
        check("feed_len", feed_cnt, NC);
      end
      feed_cnt = 0;
    end else if (Feed_En === 1'b1) begin
      check("chunk_idx", Chunk_Idx, feed_cnt);
      feed_cnt++;
    end
  end

  task automatic set_vals(input logic signed [25:0] a, b, c, d);
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
  endtask

  // Called at a negedge; the Start pulse covers cycle T = cyc
  task automatic launch(input bit expect_done);
    logic signed [25:0] s;
    s = vals[0] + vals[1] + vals[2] + vals[3];
    Start = 1'b1;
    if (expect_done) begin
      sb.push_back('{res: s, q: act(s), dcyc: cyc + NC + PL + 1});
      last_res = s;
    end
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clk);
    check("drain_timeout", 32'(sb.size() == 0), 1);
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nreset"}, Neuron_Reset, 1);
    check({tag, "_feed"}, Feed_En, 0);
    check({tag, "_cidx"}, Chunk_Idx, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_result"}, Result, 0);
    check({tag, "_result_q"}, Result_Q, 0);
  endtask

  initial begin
    Start = 1'b0; Abort = 1'b0; GlobalReset = 1'b1; garb_mode = 0; last_res = '0;
    set_vals(0, 0, 0, 0);
    repeat (3) @(negedge Clk);
    check_reset_outputs("rst");
    GlobalReset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("idle_nreset", Neuron_Reset, 1);
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
    end
    check("idle_result", Result, 0);
    check("idle_result_q", Result_Q, 0);

    // 16 lanes of 1.0 x 1.0 (Q8) per chunk, four chunks
    set_vals(26'sd4096, 26'sd4096, 26'sd4096, 26'sd4096);
    launch(1'b1);
    wait_idle();

    garb_mode = 1;
    launch(1'b1);
    wait_idle();
    repeat (10) @(negedge Clk);
    check("garbage_hold", Result, 26'sd16384);
    garb_mode = 0;

    set_vals(26'sh3FFFF00, 0, 0, 0); launch(1'b1); wait_idle();
    set_vals(26'sh0001234, 0, 0, 0); launch(1'b1); wait_idle();
    set_vals(26'sh0100000, 0, 0, 0); launch(1'b1); wait_idle();

    set_vals(26'sd1000, 26'sd2000, 26'sd3000, 26'sd4000);
    launch(1'b1);
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle();
    repeat (15) @(negedge Clk);

    set_vals(26'sd700, -26'sd50, 26'sd9000, 26'sd11);
    launch(1'b1);
    for (int i = 0; i < 100; i++) begin
      if (Done === 1'b1) break;
      @(negedge Clk);
    end
    set_vals(26'sd65536, 26'sd1, 26'sd2, 26'sd3);
    launch(1'b1);
    wait_idle();

    set_vals(26'sd300000, 26'sd0, 26'sd0, 26'sd0);
    launch(1'b0);
    repeat (6) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort_nreset", Neuron_Reset, 1);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_result", Result, last_res);
    check("abort_result_q", Result_Q, act(last_res));
    repeat (15) @(negedge Clk);
    feed_cnt = 0;

    launch(1'b0);
    repeat (6) @(negedge Clk);
    GlobalReset = 1'b1;
    @(negedge Clk);
    check_reset_outputs("grst");
    GlobalReset = 1'b0;
    feed_cnt = 0;
    repeat (3) @(negedge Clk);

    set_vals(26'sd512, 26'sd512, 26'sd512, 26'sd512);
    launch(1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
